age_reservation_station: RTL and testbench



---
 rtl/rs_pkg.sv | 34 +++
 rtl/rs_age_matrix.sv | 50 +++++
 rtl/age_reservation_station.sv | 237 +++++++++++++++++++++++
 tb/tb_age_reservation_station.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and default widths for the age-ordered reservation station.
// The feature macro RS_AGE_ORDER_EN is consumed by age_reservation_station.
package rs_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_ROB_W  = 3;
    localparam int RS_OP_W   = 4;

    typedef enum logic [RS_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } AluFunc;

    typedef struct packed {
        logic                 busy;
        logic [RS_ROB_W-1:0]  Q_i;
        logic [RS_ROB_W-1:0]  Q_j;
        logic [RS_DATA_W-1:0] V_i;
        logic [RS_DATA_W-1:0] V_j;
        logic                 i_ready;
        logic                 j_ready;
        logic [RS_ROB_W-1:0]  rob_ix;
        logic [RS_OP_W-1:0]   opcode;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Older-than matrix: r_older[i][j] set means entry i was allocated before j.
// Grants the single requester that no other requester is older than.
module rs_age_matrix
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [RS_DEPTH-1:0] i_alloc,
    input  logic [RS_DEPTH-1:0] i_free,
    input  logic [RS_DEPTH-1:0] i_req,
    input  logic                i_flush,
    output logic [RS_DEPTH-1:0] o_grant
);

    logic [RS_DEPTH-1:0] r_older [RS_DEPTH];

    // A new entry clears its own row and becomes younger than everyone else
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++)
                r_older[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < RS_DEPTH; i++)
                r_older[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (i_alloc[i] || i_free[i])
                        r_older[i][j] <= 1'b0;
                    else if (i_alloc[j])
                        r_older[i][j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            o_grant[i] = i_req[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (i_req[j] && r_older[j][i])
                    o_grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/age_reservation_station.sv
// Reservation station with CDB wakeup/bypass and one dispatch per cycle.
// Define RS_AGE_ORDER_EN for oldest-first select; otherwise lowest index wins.
module age_reservation_station
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int ROB_W    = RS_ROB_W,
    parameter int DATA_W   = RS_DATA_W,
    parameter int OP_W     = RS_OP_W,
    parameter int NUM_CDB  = 2,
    localparam int OCC_W   = $clog2(RS_DEPTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush_in,
    input  logic                      valid_input_in,
    input  logic [ROB_W-1:0]          Q_i_in,
    input  logic [ROB_W-1:0]          Q_j_in,
    input  logic [DATA_W-1:0]         V_i_in,
    input  logic [DATA_W-1:0]         V_j_in,
    input  logic                      i_ready_in,
    input  logic                      j_ready_in,
    input  logic [ROB_W-1:0]          rob_ix_in,
    input  logic [OP_W-1:0]           opcode_in,
    input  logic [NUM_CDB-1:0]        cdb_valid_in,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_ix_in,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value_in,
    input  logic                      fu_ready_in,
    output logic [DATA_W-1:0]         rval1_out,
    output logic [DATA_W-1:0]         rval2_out,
    output logic [OP_W-1:0]           opcode_out,
    output logic [ROB_W-1:0]          rob_ix_out,
    output logic                      rs_output_valid_out,
    output logic                      rs_free_for_input_out,
    output logic [OCC_W-1:0]          occupancy_out
);

    logic [RS_DEPTH-1:0] r_busy;
    logic [RS_DEPTH-1:0] r_i_rdy;
    logic [RS_DEPTH-1:0] r_j_rdy;
    logic [ROB_W-1:0]    r_q_i [RS_DEPTH];
    logic [ROB_W-1:0]    r_q_j [RS_DEPTH];
    logic [DATA_W-1:0]   r_v_i [RS_DEPTH];
    logic [DATA_W-1:0]   r_v_j [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob [RS_DEPTH];
    logic [OP_W-1:0]     r_op  [RS_DEPTH];
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_rval1;
    logic [DATA_W-1:0]   r_rval2;
    logic [OP_W-1:0]     r_opcode;
    logic [ROB_W-1:0]    r_rob_out;
    logic [OCC_W-1:0]    r_occ;

    logic [DATA_W:0]     w_byp_i;
    logic [DATA_W:0]     w_byp_j;
    logic [DATA_W:0]     w_wk_i [RS_DEPTH];
    logic [DATA_W:0]     w_wk_j [RS_DEPTH];
    logic [RS_DEPTH-1:0] w_alloc;
    logic [RS_DEPTH-1:0] w_alloc_en;
    logic [RS_DEPTH-1:0] w_elig;
    logic [RS_DEPTH-1:0] w_sel;
    logic [RS_DEPTH-1:0] w_sel_en;
    logic [RS_DEPTH-1:0] w_busy_nxt;
    logic [OCC_W-1:0]    w_occ_nxt;
    logic                w_do_issue;
    logic                w_load;
    logic [DATA_W-1:0]   w_sel_v1;
    logic [DATA_W-1:0]   w_sel_v2;
    logic [OP_W-1:0]     w_sel_op;
    logic [ROB_W-1:0]    w_sel_rob;

    // Returns {hit, value}; scanning high to low lets the lowest port win
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*ROB_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (vld[p] && tags[p*ROB_W +: ROB_W] == tag)
                res = {1'b1, vals[p*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        w_byp_i = cdb_lookup(Q_i_in, cdb_valid_in, cdb_rob_ix_in, cdb_value_in);
        w_byp_j = cdb_lookup(Q_j_in, cdb_valid_in, cdb_rob_ix_in, cdb_value_in);
        for (int e = 0; e < RS_DEPTH; e++) begin
            w_wk_i[e] = cdb_lookup(r_q_i[e], cdb_valid_in, cdb_rob_ix_in, cdb_value_in);
            w_wk_j[e] = cdb_lookup(r_q_j[e], cdb_valid_in, cdb_rob_ix_in, cdb_value_in);
        end
    end

    assign rs_free_for_input_out = ~&r_busy;
    assign w_do_issue = valid_input_in & rs_free_for_input_out & ~flush_in;

    always_comb begin
        logic w_found;
        w_alloc = '0;
        w_found = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (!r_busy[e] && !w_found) begin
                w_alloc[e] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign w_alloc_en = w_do_issue ? w_alloc : '0;
    assign w_elig     = r_busy & r_i_rdy & r_j_rdy;
    assign w_load     = (~r_out_valid | fu_ready_in) & (|w_elig) & ~flush_in;
    assign w_sel_en   = w_load ? w_sel : '0;

`ifdef RS_AGE_ORDER_EN
    rs_age_matrix #(
        .RS_DEPTH (RS_DEPTH)
    ) u_age (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_alloc (w_alloc_en),
        .i_free  (w_sel_en),
        .i_req   (w_elig),
        .i_flush (flush_in),
        .o_grant (w_sel)
    );
`else
    always_comb begin
        logic w_found;
        w_sel   = '0;
        w_found = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_elig[e] && !w_found) begin
                w_sel[e] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_sel_v1  = '0;
        w_sel_v2  = '0;
        w_sel_op  = '0;
        w_sel_rob = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_sel[e]) begin
                w_sel_v1  = r_v_i[e];
                w_sel_v2  = r_v_j[e];
                w_sel_op  = r_op[e];
                w_sel_rob = r_rob[e];
            end
        end
    end

    assign w_busy_nxt = flush_in ? '0 : ((r_busy & ~w_sel_en) | w_alloc_en);

    always_comb begin
        w_occ_nxt = '0;
        for (int e = 0; e < RS_DEPTH; e++)
            w_occ_nxt = w_occ_nxt + OCC_W'(w_busy_nxt[e]);
    end

    // Wakeup only touches operands still waiting; issue overrides it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy  <= '0;
            r_i_rdy <= '0;
            r_j_rdy <= '0;
            for (int e = 0; e < RS_DEPTH; e++) begin
                r_q_i[e] <= '0;
                r_q_j[e] <= '0;
                r_v_i[e] <= '0;
                r_v_j[e] <= '0;
                r_rob[e] <= '0;
                r_op[e]  <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (w_alloc_en[e]) begin
                    r_q_i[e]   <= Q_i_in;
                    r_q_j[e]   <= Q_j_in;
                    r_rob[e]   <= rob_ix_in;
                    r_op[e]    <= opcode_in;
                    r_i_rdy[e] <= i_ready_in | w_byp_i[DATA_W];
                    r_j_rdy[e] <= j_ready_in | w_byp_j[DATA_W];
                    r_v_i[e]   <= i_ready_in ? V_i_in : w_byp_i[DATA_W-1:0];
                    r_v_j[e]   <= j_ready_in ? V_j_in : w_byp_j[DATA_W-1:0];
                end else begin
                    if (r_busy[e] && !r_i_rdy[e] && w_wk_i[e][DATA_W]) begin
                        r_v_i[e]   <= w_wk_i[e][DATA_W-1:0];
                        r_i_rdy[e] <= 1'b1;
                    end
                    if (r_busy[e] && !r_j_rdy[e] && w_wk_j[e][DATA_W]) begin
                        r_v_j[e]   <= w_wk_j[e][DATA_W-1:0];
                        r_j_rdy[e] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_out_valid <= 1'b0;
            r_rval1     <= '0;
            r_rval2     <= '0;
            r_opcode    <= '0;
            r_rob_out   <= '0;
            r_occ       <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (flush_in) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_rval1     <= w_sel_v1;
                r_rval2     <= w_sel_v2;
                r_opcode    <= w_sel_op;
                r_rob_out   <= w_sel_rob;
            end else if (fu_ready_in) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rs_output_valid_out = r_out_valid;
    assign rval1_out           = r_rval1;
    assign rval2_out           = r_rval2;
    assign opcode_out          = r_opcode;
    assign rob_ix_out          = r_rob_out;
    assign occupancy_out       = r_occ;

endmodule

// File: tb/tb_age_reservation_station.sv
// Directed bench for age_reservation_station; expectations for dispatch
// order follow RS_AGE_ORDER_EN when the bench is built with it.
module tb_age_reservation_station;

    localparam int RS_DEPTH = 4;
    localparam int ROB_W    = 3;
    localparam int DATA_W   = 32;
    localparam int OP_W     = 4;
    localparam int NUM_CDB  = 2;
    localparam int OCC_W    = 3;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b0;
    logic                      flush_in;
    logic                      valid_input_in;
    logic [ROB_W-1:0]          Q_i_in;
    logic [ROB_W-1:0]          Q_j_in;
    logic [DATA_W-1:0]         V_i_in;
    logic [DATA_W-1:0]         V_j_in;
    logic                      i_ready_in;
    logic                      j_ready_in;
    logic [ROB_W-1:0]          rob_ix_in;
    logic [OP_W-1:0]           opcode_in;
    logic [NUM_CDB-1:0]        cdb_valid_in;
    logic [NUM_CDB*ROB_W-1:0]  cdb_rob_ix_in;
    logic [NUM_CDB*DATA_W-1:0] cdb_value_in;
    logic                      fu_ready_in;
    logic [DATA_W-1:0]         rval1_out;
    logic [DATA_W-1:0]         rval2_out;
    logic [OP_W-1:0]           opcode_out;
    logic [ROB_W-1:0]          rob_ix_out;
    logic                      rs_output_valid_out;
    logic                      rs_free_for_input_out;
    logic [OCC_W-1:0]          occupancy_out;

    int n_cmp  = 0;
    int n_fail = 0;

    age_reservation_station #(
        .RS_DEPTH (RS_DEPTH),
        .ROB_W    (ROB_W),
        .DATA_W   (DATA_W),
        .OP_W     (OP_W),
        .NUM_CDB  (NUM_CDB)
    ) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .flush_in              (flush_in),
        .valid_input_in        (valid_input_in),
        .Q_i_in                (Q_i_in),
        .Q_j_in                (Q_j_in),
        .V_i_in                (V_i_in),
        .V_j_in                (V_j_in),
        .i_ready_in            (i_ready_in),
        .j_ready_in            (j_ready_in),
        .rob_ix_in             (rob_ix_in),
        .opcode_in             (opcode_in),
        .cdb_valid_in          (cdb_valid_in),
        .cdb_rob_ix_in         (cdb_rob_ix_in),
        .cdb_value_in          (cdb_value_in),
        .fu_ready_in           (fu_ready_in),
        .rval1_out             (rval1_out),
        .rval2_out             (rval2_out),
        .opcode_out            (opcode_out),
        .rob_ix_out            (rob_ix_out),
        .rs_output_valid_out   (rs_output_valid_out),
        .rs_free_for_input_out (rs_free_for_input_out),
        .occupancy_out         (occupancy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic idle();
        valid_input_in = 1'b0;
        flush_in       = 1'b0;
        cdb_valid_in   = '0;
        cdb_rob_ix_in  = '0;
        cdb_value_in   = '0;
        Q_i_in         = '0;
        Q_j_in         = '0;
        V_i_in         = '0;
        V_j_in         = '0;
        i_ready_in     = 1'b0;
        j_ready_in     = 1'b0;
        rob_ix_in      = '0;
        opcode_in      = '0;
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic drive_issue(
        input logic [ROB_W-1:0]  rob,
        input logic [ROB_W-1:0]  qi,
        input logic              ir,
        input logic [DATA_W-1:0] vi,
        input logic [ROB_W-1:0]  qj,
        input logic              jr,
        input logic [DATA_W-1:0] vj,
        input logic [OP_W-1:0]   op
    );
        valid_input_in = 1'b1;
        rob_ix_in      = rob;
        Q_i_in         = qi;
        i_ready_in     = ir;
        V_i_in         = vi;
        Q_j_in         = qj;
        j_ready_in     = jr;
        V_j_in         = vj;
        opcode_in      = op;
    endtask

    task automatic drive_cdb(input int p, input logic [ROB_W-1:0] tag,
                             input logic [DATA_W-1:0] val);
        cdb_valid_in[p]                = 1'b1;
        cdb_rob_ix_in[p*ROB_W +: ROB_W]   = tag;
        cdb_value_in[p*DATA_W +: DATA_W] = val;
    endtask

    task automatic do_reset();
        idle();
        fu_ready_in = 1'b1;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    // Records the rob index of the next two handshakes (fu_ready held high)
    task automatic collect2(output logic [ROB_W-1:0] a,
                            output logic [ROB_W-1:0] b,
                            output bit ok);
        int got;
        got = 0;
        a = '0;
        b = '0;
        for (int c = 0; c < 12 && got < 2; c++) begin
            if (rs_output_valid_out) begin
                if (got == 0) a = rob_ix_out;
                else b = rob_ix_out;
                got++;
            end
            tick();
        end
        ok = (got == 2);
    endtask

    task automatic test_reset();
        idle();
        fu_ready_in = 1'b1;
        #1 rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({rs_output_valid_out, occupancy_out, rs_free_for_input_out} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v=%b occ=%0d free=%b, want v=0 occ=0 free=1",
                     rs_output_valid_out, occupancy_out, rs_free_for_input_out);
        end
        n_cmp++;
        if ({rval1_out, rval2_out, opcode_out, rob_ix_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h, want all 0",
                     rval1_out, rval2_out, opcode_out, rob_ix_out);
        end
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fu_ready_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_issue(3'(k + 1), 3'd0, 1'b1, 32'(k + 16), 3'd0, 1'b1, 32'h7, 4'd2);
            tick();
        end
        idle();
        n_cmp++;
        if ({occupancy_out, rs_output_valid_out} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_prefill: got occ=%0d v=%b, want occ=3 v=1",
                     occupancy_out, rs_output_valid_out);
        end
        #2 rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({rs_output_valid_out, occupancy_out, rs_free_for_input_out,
             rval1_out, rob_ix_out, opcode_out} !== {1'b0, 3'd0, 1'b1, 32'd0, 3'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b occ=%0d free=%b r1=%h rob=%0d op=%0d, want 0 0 1 0 0 0",
                     rs_output_valid_out, occupancy_out, rs_free_for_input_out,
                     rval1_out, rob_ix_out, opcode_out);
        end
        tick();
        rst_in = 1'b0;
        fu_ready_in = 1'b1;
    endtask

    task automatic test_bypass();
        do_reset();
        drive_issue(3'd5, 3'd2, 1'b0, 32'hFFFF, 3'd0, 1'b1, 32'h55, 4'd1);
        drive_cdb(0, 3'd3, 32'hDEAD);
        drive_cdb(1, 3'd2, 32'h1234);
        tick();
        idle();
        n_cmp++;
        if (rs_output_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_latency: got v=%b, want v=0", rs_output_valid_out);
        end
        tick();
        n_cmp++;
        if ({rs_output_valid_out, rval1_out, rval2_out, rob_ix_out, opcode_out, occupancy_out}
            !== {1'b1, 32'h1234, 32'h55, 3'd5, 4'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL bypass_out: got v=%b r1=%h r2=%h rob=%0d op=%0d occ=%0d, want 1 1234 55 5 1 0",
                     rs_output_valid_out, rval1_out, rval2_out, rob_ix_out, opcode_out, occupancy_out);
        end
        tick();
        n_cmp++;
        if (rs_output_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_drain: got v=%b, want v=0", rs_output_valid_out);
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        drive_issue(3'd6, 3'd4, 1'b1, 32'h11, 3'd4, 1'b0, 32'h0, 4'd3);
        tick();
        idle();
        n_cmp++;
        if (rs_output_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_wait: got v=%b, want v=0", rs_output_valid_out);
        end
        drive_cdb(0, 3'd4, 32'hAAAA);
        drive_cdb(1, 3'd4, 32'hBBBB);
        tick();
        idle();
        n_cmp++;
        if (rs_output_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_no_same_cycle: got v=%b, want v=0", rs_output_valid_out);
        end
        tick();
        n_cmp++;
        if ({rs_output_valid_out, rval1_out, rval2_out, rob_ix_out, opcode_out}
            !== {1'b1, 32'h11, 32'hAAAA, 3'd6, 4'd3}) begin
            n_fail++;
            $display("FAIL wake_out: got v=%b r1=%h r2=%h rob=%0d op=%0d, want 1 11 aaaa 6 3",
                     rs_output_valid_out, rval1_out, rval2_out, rob_ix_out, opcode_out);
        end
    endtask

    task automatic test_age_order();
        logic [ROB_W-1:0] a, b, ea, eb;
        bit ok;
        do_reset();
        drive_issue(3'd0, 3'd5, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd1, 3'd1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd2, 3'd5, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd3, 3'd3, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        idle();
        drive_cdb(0, 3'd3, 32'h33);
        drive_cdb(1, 3'd1, 32'h11);
        tick();
        idle();
        collect2(a, b, ok);
        n_cmp++;
        if (!ok || a !== 3'd1 || b !== 3'd3) begin
            n_fail++;
            $display("FAIL order_fwd: got ok=%0d %0d,%0d, want 1,3", ok, a, b);
        end

        do_reset();
        drive_issue(3'd0, 3'd6, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd1, 3'd7, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd2, 3'd6, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd3, 3'd1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        idle();
        drive_cdb(0, 3'd7, 32'h77);
        tick();
        idle();
        tick();
        drive_issue(3'd4, 3'd2, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0);
        tick();
        idle();
        drive_cdb(0, 3'd1, 32'h1);
        drive_cdb(1, 3'd2, 32'h2);
        tick();
        idle();
        collect2(a, b, ok);
`ifdef RS_AGE_ORDER_EN
        ea = 3'd3;
        eb = 3'd4;
`else
        ea = 3'd4;
        eb = 3'd3;
`endif
        n_cmp++;
        if (!ok || a !== ea || b !== eb) begin
            n_fail++;
            $display("FAIL order_rev: got ok=%0d %0d,%0d, want %0d,%0d", ok, a, b, ea, eb);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fu_ready_in = 1'b0;
        drive_issue(3'd1, 3'd0, 1'b1, 32'h101, 3'd0, 1'b1, 32'h0, 4'd2); tick();
        drive_issue(3'd2, 3'd0, 1'b1, 32'h202, 3'd0, 1'b1, 32'h0, 4'd2); tick();
        idle();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({rs_output_valid_out, rob_ix_out, rval1_out, occupancy_out}
                !== {1'b1, 3'd1, 32'h101, 3'd1}) begin
                n_fail++;
                $display("FAIL hold_c%0d: got v=%b rob=%0d r1=%h occ=%0d, want 1 1 101 1",
                         c, rs_output_valid_out, rob_ix_out, rval1_out, occupancy_out);
            end
            tick();
        end
        fu_ready_in = 1'b1;
        tick();
        n_cmp++;
        if ({rs_output_valid_out, rob_ix_out, rval1_out} !== {1'b1, 3'd2, 32'h202}) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b rob=%0d r1=%h, want 1 2 202",
                     rs_output_valid_out, rob_ix_out, rval1_out);
        end
        tick();
        n_cmp++;
        if (rs_output_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b, want 0", rs_output_valid_out);
        end
    endtask

    task automatic test_full();
        do_reset();
        drive_issue(3'd0, 3'd1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd1, 3'd2, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd2, 3'd7, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        drive_issue(3'd3, 3'd7, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, 4'd0); tick();
        idle();
        n_cmp++;
        if ({occupancy_out, rs_free_for_input_out} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_fill: got occ=%0d free=%b, want 4 0",
                     occupancy_out, rs_free_for_input_out);
        end
        drive_issue(3'd4, 3'd0, 1'b1, 32'h44, 3'd0, 1'b1, 32'h0, 4'd0);
        tick();
        idle();
        n_cmp++;
        if ({occupancy_out, rs_output_valid_out} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_ignore: got occ=%0d v=%b, want 4 0",
                     occupancy_out, rs_output_valid_out);
        end
        drive_cdb(0, 3'd1, 32'h10);
        tick();
        idle();
        tick();
        n_cmp++;
        if ({rs_output_valid_out, rob_ix_out, occupancy_out, rs_free_for_input_out}
            !== {1'b1, 3'd0, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL full_first: got v=%b rob=%0d occ=%0d free=%b, want 1 0 3 1",
                     rs_output_valid_out, rob_ix_out, occupancy_out, rs_free_for_input_out);
        end
        drive_cdb(0, 3'd2, 32'h20);
        tick();
        idle();
        drive_issue(3'd6, 3'd0, 1'b1, 32'h66, 3'd0, 1'b1, 32'h0, 4'd5);
        tick();
        idle();
        n_cmp++;
        if ({rs_output_valid_out, rob_ix_out, rval1_out, occupancy_out}
            !== {1'b1, 3'd1, 32'h20, 3'd3}) begin
            n_fail++;
            $display("FAIL full_swap: got v=%b rob=%0d r1=%h occ=%0d, want 1 1 20 3",
                     rs_output_valid_out, rob_ix_out, rval1_out, occupancy_out);
        end
        tick();
        n_cmp++;
        if ({rs_output_valid_out, rob_ix_out, rval1_out, opcode_out, occupancy_out}
            !== {1'b1, 3'd6, 32'h66, 4'd5, 3'd2}) begin
            n_fail++;
            $display("FAIL full_new: got v=%b rob=%0d r1=%h op=%0d occ=%0d, want 1 6 66 5 2",
                     rs_output_valid_out, rob_ix_out, rval1_out, opcode_out, occupancy_out);
        end
    endtask

    task automatic test_flush();
        int seen;
        fu_ready_in = 1'b0;
        flush_in = 1'b1;
        drive_issue(3'd5, 3'd0, 1'b1, 32'h5, 3'd0, 1'b1, 32'h5, 4'd0);
        drive_cdb(0, 3'd7, 32'h70);
        tick();
        idle();
        n_cmp++;
        if ({occupancy_out, rs_output_valid_out, rs_free_for_input_out} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_clear: got occ=%0d v=%b free=%b, want 0 0 1",
                     occupancy_out, rs_output_valid_out, rs_free_for_input_out);
        end
        fu_ready_in = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rs_output_valid_out) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_quiet: got %0d dispatches, want 0", seen);
        end
    endtask

    initial begin
        idle();
        fu_ready_in = 1'b1;
        test_reset();
        test_reset_mid();
        test_bypass();
        test_wakeup();
        test_age_order();
        test_back_to_back();
        test_full();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
